// File: rtl/gray_pkg.sv
// gray_pkg: shared helpers for the Gray symbol mapper and its demapper.
//   bits_per_sym() : symbol width K for a given constellation size
//   bin2gray()     : binary-reflected Gray encode, b ^ (b >> 1)
//   sym_wide_t     : widest symbol carried through the helpers; callers
//                    zero-extend into it and truncate back to K bits.
package gray_pkg;

  localparam int MAX_SYM_W = 32;

  typedef logic [MAX_SYM_W-1:0] sym_wide_t;

  function automatic int bits_per_sym(input int mod_order);
    return $clog2(mod_order);
  endfunction

  localparam int DEFAULT_MOD_ORDER = 16;
  localparam int DEFAULT_SYM_W     = bits_per_sym(DEFAULT_MOD_ORDER);

  typedef logic [DEFAULT_SYM_W-1:0] sym_t;

  function automatic sym_wide_t bin2gray(input sym_wide_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_mapper_packer.sv
// sym_packer: serial-to-parallel packer for the Gray mapper.
// Shifts accepted bits in MSB first, counts them in fill, and raises
// done combinationally on the cycle whose bit completes a K-bit symbol
// (or, with BIN2GRAY_FLUSH_EN, when a partial symbol is flushed). sym is
// the binary symbol that the top registers on that same edge.
//   clk, rst  : clock, asynchronous active-high reset
//   bit_in    : serial bit, accepted when bit_dv=1
//   flush     : pad and emit a partial symbol (BIN2GRAY_FLUSH_EN only)
//   sym       : packed binary symbol, meaningful when done=1
//   done      : symbol completes on this cycle's edge
//   fill      : bits currently held toward the next symbol (0..K-1)
module sym_packer
  import gray_pkg::*;
#(
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_dv,
`ifdef BIN2GRAY_FLUSH_EN
  input  logic             flush,
`endif
  output logic [K-1:0]     sym,
  output logic             done,
  output logic [$clog2(K):0] fill
);

  localparam int FILL_W = $clog2(K) + 1;

  logic [K-1:0]      sr_q, sr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [K-1:0]      shifted;
  logic              last;

  // With K=1 there is no history to keep: the incoming bit is the symbol.
  generate
    if (K == 1) begin : g_k1
      assign shifted = bit_in;
    end else begin : g_kn
      assign shifted = {sr_q[K-2:0], bit_in};
    end
  endgenerate

  assign last = (fill_q == FILL_W'(K - 1));

`ifdef BIN2GRAY_FLUSH_EN
  logic [K-1:0] held;
  int           held_n;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sr_d   = sr_q;
    fill_d = fill_q;
    sym    = shifted;
    done   = 1'b0;

    if (bit_dv) begin
      sr_d = shifted;
      if (last) begin
        done   = 1'b1;
        fill_d = '0;
      end else begin
        fill_d = fill_q + 1'b1;
      end
    end

`ifdef BIN2GRAY_FLUSH_EN
    // A same-cycle bit is taken first; if it completed the symbol there is
    // nothing left to pad.
    held   = bit_dv ? shifted : sr_q;
    held_n = bit_dv ? int'(fill_q) + 1 : int'(fill_q);
    if (flush && !done && held_n > 0) begin
      // The held bits sit in the LSBs; shifting them up to the MSBs both
      // drops stale history and zero-pads the remaining positions.
      sym    = held << (K - held_n);
      done   = 1'b1;
      fill_d = '0;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;

endmodule

// File: rtl/bin2gray_mapper.sv
// bin2gray_mapper: transmit-side symbol mapper. Packs a serial bit stream
// MSB first into K = log2(MODULATION_ORDER) bit symbols, Gray-encodes each
// and emits it with a one-cycle o_dv strobe. No backpressure.
// Optional feature macro: BIN2GRAY_FLUSH_EN adds i_flush, which zero-pads
// and emits a partial symbol.
//   clk, rst   : clock, asynchronous active-high reset
//   binary_bit : serial data bit, valid when i_dv=1
//   i_dv       : input bit valid
//   i_flush    : pad and emit a partial symbol (BIN2GRAY_FLUSH_EN only)
//   gray_code  : Gray-coded symbol, holds between strobes
//   o_dv       : one-cycle strobe marking a new gray_code
//   fill       : bits currently held toward the next symbol
//   sym_cnt    : emitted-symbol count, wraps modulo 2^CNT_W
module bin2gray_mapper
  import gray_pkg::*;
#(
  parameter  int MODULATION_ORDER = 16,
  parameter  int CNT_W            = 16,
  localparam int K                = bits_per_sym(MODULATION_ORDER)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               binary_bit,
  input  logic               i_dv,
`ifdef BIN2GRAY_FLUSH_EN
  input  logic               i_flush,
`endif
  output logic [K-1:0]       gray_code,
  output logic               o_dv,
  output logic [$clog2(K):0] fill,
  output logic [CNT_W-1:0]   sym_cnt
);

  generate
    if (MODULATION_ORDER < 2 ||
        (MODULATION_ORDER & (MODULATION_ORDER - 1)) != 0) begin : g_bad_order
      $error("bin2gray_mapper: MODULATION_ORDER must be a power of two >= 2");
    end
  endgenerate

  logic [K-1:0]     sym;
  logic             done;
  logic [K-1:0]     gray_code_q, gray_code_d;
  logic             o_dv_q, o_dv_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;

  sym_packer #(.K(K)) u_packer (
    .clk    (clk),
    .rst    (rst),
    .bit_in (binary_bit),
    .bit_dv (i_dv),
`ifdef BIN2GRAY_FLUSH_EN
    .flush  (i_flush),
`endif
    .sym    (sym),
    .done   (done),
    .fill   (fill)
  );

  always_comb begin
    gray_code_d = gray_code_q;
    o_dv_d      = 1'b0;
    sym_cnt_d   = sym_cnt_q;
    if (done) begin
      gray_code_d = K'(bin2gray(sym_wide_t'(sym)));
      o_dv_d      = 1'b1;
      sym_cnt_d   = sym_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_code_q <= '0;
      o_dv_q      <= 1'b0;
      sym_cnt_q   <= '0;
    end else begin
      gray_code_q <= gray_code_d;
      o_dv_q      <= o_dv_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  assign gray_code = gray_code_q;
  assign o_dv      = o_dv_q;
  assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_bin2gray_mapper.sv
// Self-checking bench for bin2gray_mapper. dut16 runs the 16-ary mapper
// (K=4), dut2 the binary case (K=1) with a 3-bit counter so its wrap is
// reached quickly. The reference model collects accepted bits in a queue
// and forms each symbol value arithmetically, MSB first.
module tb_bin2gray_mapper;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       bit16 = 1'b0, dv16 = 1'b0, flush16 = 1'b0;
  logic [3:0] gray16;
  logic       odv16;
  logic [2:0] fill16;
  logic [15:0] cnt16;

  logic       bit2 = 1'b0, dv2 = 1'b0, flush2 = 1'b0;
  logic [0:0] gray2;
  logic       odv2;
  logic [0:0] fill2;
  logic [2:0] cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // model state for dut16
  logic bit_q[$];
  int   exp_gray = 0;
  int   exp_cnt  = 0;
  logic exp_dv   = 1'b0;

  // model state for dut2
  int   exp2_gray = 0;
  int   exp2_cnt  = 0;
  logic exp2_dv   = 1'b0;

  always #5 clk = ~clk;

  bin2gray_mapper #(.MODULATION_ORDER(16), .CNT_W(16)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .binary_bit (bit16),
    .i_dv       (dv16),
`ifdef BIN2GRAY_FLUSH_EN
    .i_flush    (flush16),
`endif
    .gray_code  (gray16),
    .o_dv       (odv16),
    .fill       (fill16),
    .sym_cnt    (cnt16)
  );

  bin2gray_mapper #(.MODULATION_ORDER(2), .CNT_W(3)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .binary_bit (bit2),
    .i_dv       (dv2),
`ifdef BIN2GRAY_FLUSH_EN
    .i_flush    (flush2),
`endif
    .gray_code  (gray2),
    .o_dv       (odv2),
    .fill       (fill2),
    .sym_cnt    (cnt2)
  );

  function automatic int gray_to_bin(input int g);
    int b = 0;
    for (int s = g; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  // One clock of stimulus on dut16; updates the model, returns #1 after the edge.
  task automatic step16(input logic b, input logic dv, input logic fl);
    int v;
    @(negedge clk);
    bit16 = b; dv16 = dv; flush16 = fl;
    exp_dv = 1'b0;
    if (dv) bit_q.push_back(b);
    if (bit_q.size() == 4 || (fl && bit_q.size() > 0)) begin
      v = 0;
      for (int i = 0; i < 4; i++) v = v * 2 + ((i < bit_q.size()) ? int'(bit_q[i]) : 0);
      exp_gray = v ^ (v / 2);
      exp_dv   = 1'b1;
      exp_cnt  = (exp_cnt + 1) % 65536;
      bit_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic b, input logic dv);
    @(negedge clk);
    bit2 = b; dv2 = dv;
    exp2_dv = dv;
    if (dv) begin
      exp2_gray = int'(b);
      exp2_cnt  = (exp2_cnt + 1) % 8;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #7;
    n_checks += 8;
    if (gray16 !== 4'd0) begin n_fail++; $display("FAIL reset_gray16: got %h want 0", gray16); end
    if (odv16 !== 1'b0)  begin n_fail++; $display("FAIL reset_odv16: got %b want 0", odv16); end
    if (fill16 !== 3'd0) begin n_fail++; $display("FAIL reset_fill16: got %0d want 0", fill16); end
    if (cnt16 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt16: got %0d want 0", cnt16); end
    if (gray2 !== 1'b0)  begin n_fail++; $display("FAIL reset_gray2: got %b want 0", gray2); end
    if (odv2 !== 1'b0)   begin n_fail++; $display("FAIL reset_odv2: got %b want 0", odv2); end
    if (fill2 !== 1'b0)  begin n_fail++; $display("FAIL reset_fill2: got %b want 0", fill2); end
    if (cnt2 !== 3'd0)   begin n_fail++; $display("FAIL reset_cnt2: got %0d want 0", cnt2); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (odv16 !== 1'b0 || odv2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_strobe: got %b/%b want 0/0", odv16, odv2);
    end
  endtask

  task automatic test_basic();
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step16(pat[i], 1'b1, 1'b0);
      n_checks++;
      if (odv16 !== exp_dv) begin n_fail++; $display("FAIL basic_odv[%0d]: got %b want %b", i, odv16, exp_dv); end
    end
    n_checks += 4;
    if (gray16 !== 4'b1110) begin n_fail++; $display("FAIL basic_gray: got %b want 1110", gray16); end
    if (odv16 !== 1'b1)     begin n_fail++; $display("FAIL basic_strobe: got %b want 1", odv16); end
    if (fill16 !== 3'd0)    begin n_fail++; $display("FAIL basic_fill: got %0d want 0", fill16); end
    if (cnt16 !== 16'd1)    begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", cnt16); end
    step16(1'b0, 1'b0, 1'b0);
    n_checks += 2;
    if (odv16 !== 1'b0)     begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", odv16); end
    if (gray16 !== 4'b1110) begin n_fail++; $display("FAIL basic_hold: got %b want 1110", gray16); end
  endtask

  // Sends symbols 0..15, optionally with random idle gaps between bits.
  task automatic test_sweep(input bit with_gaps);
    int v, strobes, last_strobe, step_idx, gap;
    strobes = 0; last_strobe = 0; step_idx = 0;
    for (v = 0; v < 16; v++) begin
      for (int i = 3; i >= 0; i--) begin
        gap = with_gaps ? $urandom_range(0, 5) : 0;
        for (int g = 0; g <= gap; g++) begin
          step16((g == gap) ? v[i] : 1'($urandom_range(0, 1)), g == gap, 1'b0);
          step_idx++;
          n_checks += 3;
          if (odv16 !== exp_dv) begin n_fail++; $display("FAIL sweep_odv v=%0d: got %b want %b", v, odv16, exp_dv); end
          if (int'(fill16) !== bit_q.size()) begin n_fail++; $display("FAIL sweep_fill v=%0d: got %0d want %0d", v, fill16, bit_q.size()); end
          if (int'(gray16) !== exp_gray) begin n_fail++; $display("FAIL sweep_gray v=%0d: got %h want %h", v, gray16, exp_gray); end
          if (odv16 === 1'b1) begin
            n_checks++;
            if (gray_to_bin(int'(gray16)) !== strobes) begin
              n_fail++; $display("FAIL sweep_roundtrip: got %0d want %0d", gray_to_bin(int'(gray16)), strobes);
            end
            if (!with_gaps && strobes > 0) begin
              n_checks++;
              if (step_idx - last_strobe !== 4) begin
                n_fail++; $display("FAIL sweep_spacing: got %0d want 4", step_idx - last_strobe);
              end
            end
            last_strobe = step_idx;
            strobes++;
          end
        end
      end
    end
    n_checks += 2;
    if (strobes !== 16) begin n_fail++; $display("FAIL sweep_strobes: got %0d want 16", strobes); end
    if (int'(cnt16) !== exp_cnt) begin n_fail++; $display("FAIL sweep_cnt: got %0d want %0d", cnt16, exp_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      step16(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      n_checks += 4;
      if (odv16 !== exp_dv) begin n_fail++; $display("FAIL rand_odv n=%0d: got %b want %b", n, odv16, exp_dv); end
      if (int'(gray16) !== exp_gray) begin n_fail++; $display("FAIL rand_gray n=%0d: got %h want %h", n, gray16, exp_gray); end
      if (int'(fill16) !== bit_q.size()) begin n_fail++; $display("FAIL rand_fill n=%0d: got %0d want %0d", n, fill16, bit_q.size()); end
      if (int'(cnt16) !== exp_cnt) begin n_fail++; $display("FAIL rand_cnt n=%0d: got %0d want %0d", n, cnt16, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    if (bit_q.size() != 0) step16(1'b0, 1'b0, 1'b1);
    while (bit_q.size() != 0) step16(1'b0, 1'b1, 1'b0);
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    dv16 = 1'b0;
    #2 rst = 1'b1;
    bit_q.delete(); exp_gray = 0; exp_cnt = 0; exp_dv = 1'b0;
    #1;
    n_checks += 3;
    if (fill16 !== 3'd0) begin n_fail++; $display("FAIL rstmid_fill: got %0d want 0", fill16); end
    if (cnt16 !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", cnt16); end
    if (gray16 !== 4'd0) begin n_fail++; $display("FAIL rstmid_gray: got %h want 0", gray16); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step16(1'b1, i < 4, 1'b0);
      if (odv16 === 1'b1) begin
        strobes++;
        n_checks++;
        if (gray16 !== 4'b1000) begin n_fail++; $display("FAIL rstmid_gray1111: got %b want 1000", gray16); end
      end
    end
    n_checks += 2;
    if (strobes !== 1) begin n_fail++; $display("FAIL rstmid_strobes: got %0d want 1", strobes); end
    if (cnt16 !== 16'd1) begin n_fail++; $display("FAIL rstmid_cnt_after: got %0d want 1", cnt16); end
  endtask

`ifdef BIN2GRAY_FLUSH_EN
  task automatic test_flush();
    int strobes = 0;
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b0, 1'b0, 1'b1);
    n_checks += 3;
    if (odv16 !== 1'b1)     begin n_fail++; $display("FAIL flush_strobe: got %b want 1", odv16); end
    if (gray16 !== 4'b1010) begin n_fail++; $display("FAIL flush_gray: got %b want 1010", gray16); end
    if (fill16 !== 3'd0)    begin n_fail++; $display("FAIL flush_fill: got %0d want 0", fill16); end
    step16(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (odv16 !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", odv16); end
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b0, 1'b1, 1'b0);
    step16(1'b1, 1'b1, 1'b0);
    step16(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (odv16 !== exp_dv) begin n_fail++; $display("FAIL flush_same_odv[%0d]: got %b want %b", i, odv16, exp_dv); end
      if (odv16 === 1'b1) strobes++;
      if (i < 2) step16(1'b0, 1'b0, 1'b0);
    end
    n_checks += 2;
    if (strobes !== 1) begin n_fail++; $display("FAIL flush_same_strobes: got %0d want 1", strobes); end
    if (int'(gray16) !== exp_gray) begin n_fail++; $display("FAIL flush_same_gray: got %h want %h", gray16, exp_gray); end
  endtask
`endif

  task automatic test_k1();
    logic pat [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step2(pat[i], 1'b1);
      n_checks += 3;
      if (odv2 !== 1'b1) begin n_fail++; $display("FAIL k1_odv[%0d]: got %b want 1", i, odv2); end
      if (gray2 !== pat[i]) begin n_fail++; $display("FAIL k1_gray[%0d]: got %b want %b", i, gray2, pat[i]); end
      if (fill2 !== 1'b0) begin n_fail++; $display("FAIL k1_fill[%0d]: got %b want 0", i, fill2); end
    end
    for (int n = 0; n < 14; n++) begin
      step2(1'($urandom_range(0, 1)), (n < 5) ? 1'b1 : 1'($urandom_range(0, 1)));
      n_checks += 3;
      if (odv2 !== exp2_dv) begin n_fail++; $display("FAIL k1_rand_odv n=%0d: got %b want %b", n, odv2, exp2_dv); end
      if (int'(gray2) !== exp2_gray) begin n_fail++; $display("FAIL k1_rand_gray n=%0d: got %b want %0d", n, gray2, exp2_gray); end
      if (int'(cnt2) !== exp2_cnt) begin n_fail++; $display("FAIL k1_cnt n=%0d: got %0d want %0d", n, cnt2, exp2_cnt); end
      if (n == 4) begin
        n_checks++;
        if (cnt2 !== 3'd0) begin n_fail++; $display("FAIL k1_wrap: got %0d want 0", cnt2); end
      end
    end
    step2(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_random();
    test_reset_mid();
`ifdef BIN2GRAY_FLUSH_EN
    test_flush();
`endif
    test_k1();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
